eth_rx_fcs_check: RTL and testbench
===================================

# eth_rx_fcs_check

Receive-side Ethernet MII frame checker. It sits between the PHY MII receive pins and the RX MAC buffer. It strips preamble/SFD, assembles nibbles into bytes, runs CRC32 over the frame, and removes the 4-byte FCS from the output byte stream. At frame end it reports a good/bad verdict with per-cause error bits.

## Interface
- `MIN_FRAME`, default 64: minimum frame length in bytes, FCS included; shorter frames are runts.
- `MAX_FRAME`, default 1518: maximum frame length in bytes, FCS included; longer frames are oversize.
- `clk`  in  1  MII RX clock (25 MHz for 100M); all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mii_rxd`  in  4  receive nibble, low nibble of each byte first.
- `mii_rx_dv`  in  1  receive data valid.
- `mii_rx_er`  in  1  receive error.
- `m_data`  out  8  payload byte (FCS excluded).
- `m_valid`  out  1  one-cycle strobe per payload byte; no backpressure.
- `m_last`  out  1  with `m_valid`: final payload byte.
- `m_good`  out  1  with `m_last`: frame passed all checks.
- `stat_valid`  out  1  one-cycle strobe at every frame end that reached DATA.
- `stat_err`  out  5  with `stat_valid`; bit meanings:
  - [0] CRC mismatch
  - [1] `rx_er` seen
  - [2] odd nibble count
  - [3] runt
  - [4] oversize
- `stat_len`  out  11  with `stat_valid`: byte count including FCS, saturating at 2047.

## Operation
- MII inputs are registered once on entry; all behaviour below refers to registered samples.
- States and transitions:
  - **IDLE**: waits for the armed condition. Armed means a `rx_dv`=0 sample has been seen since reset or since the last frame.
    - Armed, `dv`=1, nibble 0x5 -> PREAMBLE.
    - Armed, `dv`=1, any other nibble -> DROP.
  - **PREAMBLE**:
    - nibble 0x5 -> stay.
    - nibble 0xD -> DATA; CRC is initialised to 0xFFFFFFFF and the counters are cleared.
    - any other nibble -> DROP.
    - `dv`=0 -> IDLE, no status.
  - **DATA**: every sample with `dv`=1 feeds the nibble into the CRC. CRC update uses the codebase's nibble-wide right-shifting CRC32 step (poly 0xEDB88320, bit 0 first). Even nibble = low half, odd nibble = high half; the byte completes on the odd nibble. `dv`=0 -> END.
  - **END**: single cycle; evaluates checks, emits status -> IDLE (armed).
  - **DROP**: waits for `dv`=0 -> IDLE. Emits no output and no status.
- FCS stripping uses a 5-entry byte shift register.
  - On completion of byte k (k ≥ 5), byte k-5 is emitted with `m_valid`=1.
  - In END, if byte count ≥ 5, the oldest held byte is emitted with `m_last`=1 and `m_good`=(`stat_err`==0).
  - The remaining 4 held bytes are the FCS and are discarded.
  - With fewer than 5 bytes, no `m_last` is emitted; status is still reported.
- Checks in END:
  - CRC register ≠ 0xDEBB20E3 (reflected residue, no inversion) -> bit 0.
  - Any `rx_er`=1 sample in DATA -> bit 1. The error is sticky; the frame keeps streaming.
  - Odd nibble count -> bit 2. The trailing half-nibble is discarded and not emitted.
  - Bytes < `MIN_FRAME` -> bit 3.
  - Bytes > `MAX_FRAME` -> bit 4. Output continues; the counter saturates.
- Reset mid-frame:
  - All outputs go to 0 immediately, state IDLE, disarmed.
  - The remainder of the interrupted frame is ignored until `dv` is seen low.

## Timing
- Reset values: `m_data`=0, `m_valid`=0, `m_last`=0, `m_good`=0, `stat_valid`=0, `stat_err`=0, `stat_len`=0.
- All outputs are registered.
- Pin-to-`m_valid` latency:
  - Input register: 1 cycle.
  - Byte k-5 strobes on the cycle after the sample holding byte k's high nibble.
- END is the cycle after the first `dv`=0 sample. `stat_valid` and the `m_last` byte are both asserted the following cycle, simultaneously.
- `m_valid` duty cycle is at most 1 in 2; consecutive strobes are never adjacent in DATA.
- A new frame's preamble may start on the cycle after the `dv`=0 sample. The block must accept it, because END consumes no input sample.
- Back-to-back frames with a minimum interframe gap of 1 nibble must not lose status.

## Structure
- Shared package `eth_pkg` holds:
  - constants `CRC32_POLY`=0xEDB88320, `CRC32_INIT`=0xFFFFFFFF, `CRC32_RESIDUE`=0xDEBB20E3, `PREAMBLE_NIB`=0x5, `SFD_NIB`=0xD;
  - the `rx_state_t` enum;
  - `stat_err` bit index localparams.
- The nibble CRC step is instantiated as a combinational sub-module. The FSM, byte assembler, delay line and counters live in this module.

## Test plan
- Good frame, `MIN_FRAME`=13:
  - Stimulus: 7×0x55, 0xD5, payload "123456789" (0x31..0x39), FCS bytes 26 39 F4 CB.
  - Expect 9 strobes 0x31..0x39, `m_last` on 0x39, `m_good`=1, `stat_err`=0, `stat_len`=13.
- Same frame with FCS 26 39 F4 CA -> `stat_err`=5'b00001, `m_good`=0, all 9 bytes still emitted.
- 64-byte frame with `rx_er` pulsed on nibble 40 and valid FCS -> `stat_err`=5'b00010, 60 bytes emitted.
- Good 13-byte frame plus one extra nibble, default `MIN_FRAME` -> `stat_err`=5'b01100, `stat_len`=13.
- Preamble broken by nibble 0x3 -> DROP; no `m_valid`, no `stat_valid`. A following good frame after a 1-nibble gap -> fully correct.
- `rst_n` pulsed low at payload byte 20 with `dv` still high -> outputs 0 at once, no strobes for the rest of that frame. The next frame is received good.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet receive definitions: CRC32 constants, receive FSM states
// and the bit layout of the per-frame error vector.
package eth_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;
  localparam logic [3:0]  PREAMBLE_NIB  = 4'h5;
  localparam logic [3:0]  SFD_NIB       = 4'hD;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_END,
    ST_DROP
  } rx_state_t;

  localparam int STAT_ERR_W   = 5;
  localparam int ERR_CRC      = 0;
  localparam int ERR_RX_ER    = 1;
  localparam int ERR_ODD_NIB  = 2;
  localparam int ERR_RUNT     = 3;
  localparam int ERR_OVERSIZE = 4;

endpackage

// File: rtl/eth_rx_fcs_check_crc.sv
// One nibble of the reflected CRC32 (bit 0 first, right-shifting register).
module eth_rx_fcs_check_crc
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [3:0]  nib,
  output logic [31:0] crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < 4; i++) begin
      crc_out = (crc_out >> 1) ^ (((crc_out[0] ^ nib[i]) != 1'b0) ? CRC32_POLY : 32'h0);
    end
  end

endmodule

// File: rtl/eth_rx_fcs_check.sv
// MII receive frame checker: strips preamble/SFD, assembles bytes, checks
// CRC32, holds back the 4 FCS bytes and reports a per-frame verdict.
module eth_rx_fcs_check
  import eth_pkg::*;
#(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            mii_rxd,
  input  logic                  mii_rx_dv,
  input  logic                  mii_rx_er,
  output logic [7:0]            m_data,
  output logic                  m_valid,
  output logic                  m_last,
  output logic                  m_good,
  output logic                  stat_valid,
  output logic [STAT_ERR_W-1:0] stat_err,
  output logic [10:0]           stat_len
);

  localparam logic [10:0] LEN_SAT = 11'h7FF;
  localparam logic [10:0] MIN_LEN = 11'(MIN_FRAME);
  localparam logic [10:0] MAX_LEN = 11'(MAX_FRAME);
  localparam logic [10:0] HOLD    = 11'd5;

  logic [3:0] rxd_q;
  logic       dv_q, er_q, smp_ok_q;

  rx_state_t       state_q, state_d;
  logic            armed_q, armed_d;
  logic [31:0]     crc_q, crc_d, crc_byte_q, crc_byte_d, crc_next;
  logic            odd_q, odd_d;
  logic [3:0]      lo_q, lo_d;
  logic [10:0]     cnt_q, cnt_d;
  logic            er_seen_q, er_seen_d;
  logic [4:0][7:0] dly_q, dly_d;

  logic [7:0]            m_data_q, m_data_d;
  logic                  m_valid_q, m_valid_d, m_last_q, m_last_d, m_good_q, m_good_d;
  logic                  stat_valid_q, stat_valid_d;
  logic [STAT_ERR_W-1:0] stat_err_q, stat_err_d, err_vec;
  logic [10:0]           stat_len_q, stat_len_d;

  eth_rx_fcs_check_crc u_crc (
    .crc_in  (crc_q),
    .nib     (rxd_q),
    .crc_out (crc_next)
  );

  // smp_ok_q keeps the reset value of dv_q from counting as a real dv=0 sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_q    <= '0;
      dv_q     <= 1'b0;
      er_q     <= 1'b0;
      smp_ok_q <= 1'b0;
    end else begin
      rxd_q    <= mii_rxd;
      dv_q     <= mii_rx_dv;
      er_q     <= mii_rx_er;
      smp_ok_q <= 1'b1;
    end
  end

  // The CRC is judged at the last byte boundary so a trailing half-nibble
  // only raises the odd-nibble error.
  always_comb begin
    err_vec               = '0;
    err_vec[ERR_CRC]      = (crc_byte_q != CRC32_RESIDUE);
    err_vec[ERR_RX_ER]    = er_seen_q;
    err_vec[ERR_ODD_NIB]  = odd_q;
    err_vec[ERR_RUNT]     = (cnt_q < MIN_LEN);
    err_vec[ERR_OVERSIZE] = (cnt_q > MAX_LEN);
  end

  always_comb begin
    // NOTE: every _d gets a default first, so no path through the case can infer a latch.
    state_d      = state_q;
    armed_d      = armed_q;
    crc_d        = crc_q;
    crc_byte_d   = crc_byte_q;
    odd_d        = odd_q;
    lo_d         = lo_q;
    cnt_d        = cnt_q;
    er_seen_d    = er_seen_q;
    dly_d        = dly_q;
    m_data_d     = m_data_q;
    m_valid_d    = 1'b0;
    m_last_d     = 1'b0;
    m_good_d     = 1'b0;
    stat_valid_d = 1'b0;
    stat_err_d   = stat_err_q;
    stat_len_d   = stat_len_q;

    if (smp_ok_q && !dv_q) armed_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (armed_q && dv_q) begin
          armed_d = 1'b0;
          state_d = (rxd_q == PREAMBLE_NIB) ? ST_PREAMBLE : ST_DROP;
        end
      end
      ST_PREAMBLE: begin
        if (!dv_q) begin
          state_d = ST_IDLE;
        end else if (rxd_q == SFD_NIB) begin
          state_d    = ST_DATA;
          crc_d      = CRC32_INIT;
          crc_byte_d = CRC32_INIT;
          cnt_d      = '0;
          odd_d      = 1'b0;
          er_seen_d  = 1'b0;
        end else if (rxd_q != PREAMBLE_NIB) begin
          state_d = ST_DROP;
        end
      end
      ST_DATA: begin
        if (!dv_q) begin
          state_d = ST_END;
        end else begin
          crc_d = crc_next;
          if (er_q) er_seen_d = 1'b1;
          if (!odd_q) begin
            lo_d  = rxd_q;
            odd_d = 1'b1;
          end else begin
            odd_d      = 1'b0;
            crc_byte_d = crc_next;
            dly_d      = {dly_q[3:0], rxd_q, lo_q};
            cnt_d      = (cnt_q == LEN_SAT) ? cnt_q : cnt_q + 11'd1;
            if (cnt_q >= HOLD) begin
              m_valid_d = 1'b1;
              m_data_d  = dly_q[4];
            end
          end
        end
      end
      ST_END: begin
        state_d      = ST_IDLE;
        armed_d      = 1'b1;
        stat_valid_d = 1'b1;
        stat_err_d   = err_vec;
        stat_len_d   = cnt_q;
        if (cnt_q >= HOLD) begin
          m_valid_d = 1'b1;
          m_last_d  = 1'b1;
          m_good_d  = (err_vec == '0);
          m_data_d  = dly_q[4];
        end
      end
      ST_DROP: begin
        if (!dv_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      armed_q      <= 1'b0;
      crc_q        <= CRC32_INIT;
      crc_byte_q   <= CRC32_INIT;
      odd_q        <= 1'b0;
      lo_q         <= '0;
      cnt_q        <= '0;
      er_seen_q    <= 1'b0;
      // NOTE: the delay line is only five bytes, so resetting it costs little and keeps m_data free of X.
      dly_q        <= '0;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      m_good_q     <= 1'b0;
      stat_valid_q <= 1'b0;
      stat_err_q   <= '0;
      stat_len_q   <= '0;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      crc_q        <= crc_d;
      crc_byte_q   <= crc_byte_d;
      odd_q        <= odd_d;
      lo_q         <= lo_d;
      cnt_q        <= cnt_d;
      er_seen_q    <= er_seen_d;
      dly_q        <= dly_d;
      m_data_q     <= m_data_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
      m_good_q     <= m_good_d;
      stat_valid_q <= stat_valid_d;
      stat_err_q   <= stat_err_d;
      stat_len_q   <= stat_len_d;
    end
  end

  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign m_last     = m_last_q;
  assign m_good     = m_good_q;
  assign stat_valid = stat_valid_q;
  assign stat_err   = stat_err_q;
  assign stat_len   = stat_len_q;

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Bench for eth_rx_fcs_check: two instances (MIN_FRAME 13 and default) share
// the MII stimulus; a byte-level frame model predicts payload and status.
module tb_eth_rx_fcs_check;
  import eth_pkg::*;

  localparam int NU = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] mii_rxd = 4'h0;
  logic       mii_rx_dv = 1'b0;
  logic       mii_rx_er = 1'b0;

  logic [7:0]  m_data[NU];
  logic        m_valid[NU], m_last[NU], m_good[NU], stat_valid[NU];
  logic [4:0]  stat_err[NU];
  logic [10:0] stat_len[NU];

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  got_b[NU][$], exp_b[NU][$];
  logic [17:0] got_s[NU][$], exp_s[NU][$];
  int          stray[NU], adj[NU];
  logic        prev_v[NU];

  always #20 clk = ~clk;

  eth_rx_fcs_check #(.MIN_FRAME(13)) dut_min13 (
    .clk(clk), .rst_n(rst_n), .mii_rxd(mii_rxd), .mii_rx_dv(mii_rx_dv), .mii_rx_er(mii_rx_er),
    .m_data(m_data[0]), .m_valid(m_valid[0]), .m_last(m_last[0]), .m_good(m_good[0]),
    .stat_valid(stat_valid[0]), .stat_err(stat_err[0]), .stat_len(stat_len[0])
  );

  eth_rx_fcs_check dut_def (
    .clk(clk), .rst_n(rst_n), .mii_rxd(mii_rxd), .mii_rx_dv(mii_rx_dv), .mii_rx_er(mii_rx_er),
    .m_data(m_data[1]), .m_valid(m_valid[1]), .m_last(m_last[1]), .m_good(m_good[1]),
    .stat_valid(stat_valid[1]), .stat_err(stat_err[1]), .stat_len(stat_len[1])
  );

  always @(negedge clk) begin
    for (int u = 0; u < NU; u++) begin
      if (m_valid[u] === 1'b1) got_b[u].push_back(m_data[u]);
      if (m_valid[u] === 1'b1 && prev_v[u] === 1'b1) adj[u]++;
      prev_v[u] = m_valid[u];
      if (stat_valid[u] === 1'b1)
        got_s[u].push_back({m_valid[u] & m_last[u], m_good[u], stat_err[u], stat_len[u]});
      else if (m_last[u] !== 1'b0 || m_good[u] !== 1'b0)
        stray[u]++;
    end
  end

  function automatic int min_of(input int u);
    return (u == 0) ? 13 : 64;
  endfunction

  function automatic logic [31:0] crc32(input logic [7:0] d[$], input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, d[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nib(input logic [3:0] d, input logic dv, input logic er);
    @(negedge clk);
    mii_rxd   = d;
    mii_rx_dv = dv;
    mii_rx_er = er;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) nib(4'h0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int u = 0; u < NU; u++)
      check($sformatf("%s/u%0d/outputs", tag, u),
            32'({m_data[u], m_valid[u], m_last[u], m_good[u], stat_valid[u], stat_err[u], stat_len[u]}),
            32'h0);
  endtask

  task automatic flush_got();
    for (int u = 0; u < NU; u++) begin
      got_b[u].delete();
      got_s[u].delete();
      stray[u]  = 0;
      adj[u]    = 0;
      prev_v[u] = 1'b0;
    end
  endtask

  // Frame model: payload is everything but the last 4 bytes; verdict from the byte-level rules.
  task automatic expect_frame(input logic [7:0] fr[$], input bit er, input bit odd);
    int          n;
    logic [31:0] fcs;
    logic [4:0]  e;
    n   = fr.size();
    fcs = {fr[n-1], fr[n-2], fr[n-3], fr[n-4]};
    for (int u = 0; u < NU; u++) begin
      e    = '0;
      e[0] = (crc32(fr, n - 4) != fcs);
      e[1] = er;
      e[2] = odd;
      e[3] = (n < min_of(u));
      e[4] = (n > 1518);
      for (int i = 0; i < n - 4; i++) exp_b[u].push_back(fr[i]);
      exp_s[u].push_back({(n >= 5), (n >= 5) && (e == 5'd0), e, (n > 2047) ? 11'd2047 : 11'(n)});
    end
  endtask

  task automatic send_frame(input logic [7:0] fr[$], input int er_nib, input bit odd,
                            input int brk, input int rst_byte, input int gap);
    for (int i = 0; i < 16; i++)
      nib((i == 15) ? SFD_NIB : ((i == brk) ? 4'h3 : PREAMBLE_NIB), 1'b1, 1'b0);
    for (int b = 0; b < fr.size(); b++) begin
      nib(fr[b][3:0], 1'b1, (2 * b == er_nib));
      if (b == rst_byte) begin
        #5 rst_n = 1'b0;
        #1 check_reset_outputs("mid_reset");
        flush_got();
      end
      nib(fr[b][7:4], 1'b1, (2 * b + 1 == er_nib));
      if (b == rst_byte) #5 rst_n = 1'b1;
    end
    if (odd) nib(4'($urandom), 1'b1, 1'b0);
    idle(gap);
  endtask

  task automatic run(input logic [7:0] fr[$], input int er_nib, input bit odd, input int gap);
    expect_frame(fr, er_nib >= 0, odd);
    send_frame(fr, er_nib, odd, -1, -1, gap);
  endtask

  task automatic make_frame(input int n, input bit good, output logic [7:0] fr[$]);
    logic [31:0] fcs;
    fr.delete();
    for (int i = 0; i < n - 4; i++) fr.push_back(8'($urandom));
    fcs = crc32(fr, n - 4);
    if (!good) fcs = fcs ^ (32'h1 << $urandom_range(0, 31));
    for (int i = 0; i < 4; i++) fr.push_back(fcs[8*i +: 8]);
  endtask

  task automatic compare(input string tag);
    idle(8);
    for (int u = 0; u < NU; u++) begin
      int nb, ns;
      check($sformatf("%s/u%0d/n_bytes", tag, u), 32'(got_b[u].size()), 32'(exp_b[u].size()));
      nb = (got_b[u].size() < exp_b[u].size()) ? got_b[u].size() : exp_b[u].size();
      for (int i = 0; i < nb; i++)
        check($sformatf("%s/u%0d/byte%0d", tag, u, i), 32'(got_b[u][i]), 32'(exp_b[u][i]));
      check($sformatf("%s/u%0d/n_stat", tag, u), 32'(got_s[u].size()), 32'(exp_s[u].size()));
      ns = (got_s[u].size() < exp_s[u].size()) ? got_s[u].size() : exp_s[u].size();
      for (int i = 0; i < ns; i++) begin
        check($sformatf("%s/u%0d/f%0d/stat_len", tag, u, i), 32'(got_s[u][i][10:0]), 32'(exp_s[u][i][10:0]));
        check($sformatf("%s/u%0d/f%0d/stat_err", tag, u, i), 32'(got_s[u][i][15:11]), 32'(exp_s[u][i][15:11]));
        check($sformatf("%s/u%0d/f%0d/m_good", tag, u, i), 32'(got_s[u][i][16]), 32'(exp_s[u][i][16]));
        check($sformatf("%s/u%0d/f%0d/m_last", tag, u, i), 32'(got_s[u][i][17]), 32'(exp_s[u][i][17]));
      end
      check($sformatf("%s/u%0d/stray_last", tag, u), 32'(stray[u]), 32'h0);
      check($sformatf("%s/u%0d/adjacent_valid", tag, u), 32'(adj[u]), 32'h0);
      exp_b[u].delete();
      exp_s[u].delete();
    end
    flush_got();
  endtask

  initial begin
    logic [7:0] fr[$];
    logic [7:0] f2[$];
    int         n, er_nib;

    flush_got();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    idle(4);

    // "123456789" with its known FCS, then a one-bit-off FCS.
    for (int i = 0; i < 9; i++) fr.push_back(8'h31 + 8'(i));
    fr.push_back(8'h26); fr.push_back(8'h39); fr.push_back(8'hF4); fr.push_back(8'hCB);
    run(fr, -1, 1'b0, 4);
    compare("good13");
    f2 = fr;
    f2[12] = 8'hCA;
    run(f2, -1, 1'b0, 4);
    compare("bad_fcs13");

    make_frame(64, 1'b1, fr);
    run(fr, 40, 1'b0, 4);
    compare("rx_er64");

    f2 = fr;
    fr.delete();
    for (int i = 0; i < 9; i++) fr.push_back(8'h31 + 8'(i));
    fr.push_back(8'h26); fr.push_back(8'h39); fr.push_back(8'hF4); fr.push_back(8'hCB);
    run(fr, -1, 1'b1, 4);
    compare("odd_nibble");

    make_frame(4, 1'b1, fr);
    run(fr, -1, 1'b0, 3);
    make_frame(5, 1'b1, fr);
    run(fr, -1, 1'b0, 3);
    compare("len4_len5");

    make_frame(20, 1'b1, fr);
    send_frame(fr, -1, 1'b0, 3, -1, 1);
    make_frame(30, 1'b1, fr);
    run(fr, -1, 1'b0, 1);
    compare("drop_then_good");

    make_frame(64, 1'b1, fr);
    send_frame(fr, -1, 1'b0, -1, 20, 2);
    make_frame(70, 1'b1, fr);
    run(fr, -1, 1'b0, 4);
    compare("reset_mid_frame");

    make_frame(1520, 1'b1, fr);
    run(fr, -1, 1'b0, 4);
    make_frame(2100, 1'b1, fr);
    run(fr, -1, 1'b0, 4);
    compare("oversize");

    for (int batch = 0; batch < 4; batch++) begin
      for (int k = 0; k < 6; k++) begin
        n = $urandom_range(4, 90);
        make_frame(n, $urandom_range(0, 3) != 0, fr);
        er_nib = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 2 * n - 1)) : -1;
        run(fr, er_nib, $urandom_range(0, 4) == 0, $urandom_range(1, 3));
      end
      compare($sformatf("random%0d", batch));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
